// File: rtl/mul8_rr_scheduler.sv
// Round-robin scheduler sharing one signed 8x8 multiplier among NUM_REQ requesters
// through a 2-stage pipeline. Optional issue counter: define MUL8_SCHED_STATS_EN.
module mul8_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [8*NUM_REQ-1:0] req_operand_a,
    input  logic [8*NUM_REQ-1:0] req_operand_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [15:0]          rsp_result
`ifdef MUL8_SCHED_STATS_EN
    ,
    output logic [15:0]          stat_issue_cnt
`endif
);

    logic [ID_W-1:0]    ptr;
    logic               s1_valid;
    logic [7:0]         s1_a;
    logic [7:0]         s1_b;
    logic [ID_W-1:0]    s1_id;
    logic               adv1;
    logic               adv2;
    logic               accept;
    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    logic [NUM_REQ-1:0] grant_oh;
    logic [7:0]         grant_a;
    logic [7:0]         grant_b;
    logic signed [15:0] product;

    assign adv2 = !rsp_valid || rsp_ready;
    assign adv1 = !s1_valid || adv2;

    // Two passes: requesters at or above ptr first, then the wrapped-around ones.
    always_comb begin
        // NOTE: every output gets a default before the search so no latch is inferred.
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_oh    = '0;
        grant_a     = '0;
        grant_b     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && req_valid[k] && (k >= int'(ptr))) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(k);
                grant_oh[k] = 1'b1;
                grant_a     = req_operand_a[8*k +: 8];
                grant_b     = req_operand_b[8*k +: 8];
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && req_valid[k]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(k);
                grant_oh[k] = 1'b1;
                grant_a     = req_operand_a[8*k +: 8];
                grant_b     = req_operand_b[8*k +: 8];
            end
        end
    end

    assign req_ready = (!rst && adv1 && grant_found) ? grant_oh : '0;
    assign accept    = |req_ready;
    assign product   = $signed(s1_a) * $signed(s1_b);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            ptr        <= '0;
            s1_valid   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
        end else begin
            if (accept) begin
                ptr      <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
                s1_valid <= 1'b1;
            end else if (adv1) begin
                s1_valid <= 1'b0;
            end
            if (adv2) begin
                rsp_valid <= s1_valid;
                if (s1_valid) begin
                    rsp_id     <= s1_id;
                    rsp_result <= product;
                end
            end
        end
    end

    // NOTE: stage-1 payload has no reset; it is only observed behind s1_valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_a  <= grant_a;
            s1_b  <= grant_b;
            s1_id <= grant_idx;
        end
    end

`ifdef MUL8_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issue_cnt <= '0;
        end else if (accept) begin
            stat_issue_cnt <= stat_issue_cnt + 16'd1;
        end
    end
`else
    // Statistics disabled: no issue counter is built.
`endif

endmodule

// File: tb/tb_mul8_rr_scheduler.sv
// Directed self-checking bench for mul8_rr_scheduler (NUM_REQ=4, ID_W=2); inputs change
// 1 ns after the rising edge and outputs are sampled 1 ns later.
module tb_mul8_rr_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_result;
`ifdef MUL8_SCHED_STATS_EN
    logic [15:0] stat_issue_cnt;
`endif

    int num_checks = 0;
    int num_fail   = 0;

    mul8_rr_scheduler #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_operand_a (op_a),
        .req_operand_b (op_b),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_result    (rsp_result)
`ifdef MUL8_SCHED_STATS_EN
        ,
        .stat_issue_cnt(stat_issue_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        num_checks++;
        if (obs !== exp) begin
            num_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int k, input logic [7:0] a, input logic [7:0] b);
        op_a[8*k +: 8] = a;
        op_b[8*k +: 8] = b;
    endtask

    task automatic check_rsp(input string tag, input logic [1:0] id, input logic [15:0] res);
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_id"}, 32'(rsp_id), 32'(id));
        check({tag, "_result"}, 32'(rsp_result), 32'(res));
    endtask

    logic [7:0]  corner_a [3] = '{8'h80, 8'h80, 8'h00};
    logic [7:0]  corner_b [3] = '{8'h80, 8'h7F, 8'hFF};
    logic [15:0] corner_p [3] = '{16'h4000, 16'hC080, 16'h0000};

    initial begin
        rst       = 1'b1;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        op_a      = '0;
        op_b      = '0;

        // Reset behaviour
        tick();
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_id", 32'(rsp_id), 32'h0);
        check("rst_rsp_result", 32'(rsp_result), 32'h0);
        rst       = 1'b0;
        req_valid = 4'h0;
        tick();

        // Single op from req0: 7 * -3
        set_op(0, 8'h07, 8'hFD);
        req_valid = 4'b0001;
        #1 check("single_ready", 32'(req_ready), 32'b0001);
        tick();
        req_valid = 4'b0000;
        #1 check("single_s1_only", 32'(rsp_valid), 32'h0);
        tick();
        check_rsp("single", 2'd0, 16'hFFEB);
        tick();

        // Corner products streamed back-to-back from req1
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                set_op(1, corner_a[i], corner_b[i]);
                req_valid = 4'b0010;
            end else begin
                req_valid = 4'b0000;
            end
            #1;
            if (i < 3) check($sformatf("corner%0d_ready", i), 32'(req_ready), 32'b0010);
            if (i >= 2) check_rsp($sformatf("corner%0d", i - 2), 2'd1, corner_p[i-2]);
            tick();
        end

        // Reset with both stages full
        rsp_ready = 1'b0;
        set_op(0, 8'h01, 8'h01);
        req_valid = 4'b0001;
        #1 check("mid_ready0", 32'(req_ready), 32'b0001);
        tick();
        set_op(0, 8'h02, 8'h02);
        #1 check("mid_ready1", 32'(req_ready), 32'b0001);
        tick();
        check("mid_full_valid", 32'(rsp_valid), 32'h1);
        check("mid_full_ready", 32'(req_ready), 32'h0);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 32'(rsp_valid), 32'h0);
        check("mid_rst_id", 32'(rsp_id), 32'h0);
        check("mid_rst_result", 32'(rsp_result), 32'h0);
        check("mid_rst_ready", 32'(req_ready), 32'h0);
`ifdef MUL8_SCHED_STATS_EN
        check("mid_rst_stat", 32'(stat_issue_cnt), 32'h0);
`endif
        rst       = 1'b0;
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        tick();
        check("mid_discard0", 32'(rsp_valid), 32'h0);
        tick();
        check("mid_discard1", 32'(rsp_valid), 32'h0);

        // Fairness: all requesters valid, product = (k+1)*10; first grant shows ptr=0 after reset
        op_a = 32'h04030201;
        op_b = 32'h0A0A0A0A;
        for (int i = 0; i < 10; i++) begin
            req_valid = (i < 8) ? 4'hF : 4'h0;
            #1;
            if (i < 8) check($sformatf("fair%0d_ready", i), 32'(req_ready), 32'(4'b0001 << (i % 4)));
            if (i >= 2) check_rsp($sformatf("fair%0d", i - 2), 2'((i - 2) % 4), 16'(((i - 2) % 4 + 1) * 10));
            tick();
        end

        // Backpressure from req2
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        set_op(2, 8'h03, 8'h05);
        #1 check("bp_ready0", 32'(req_ready), 32'b0100);
        tick();
        set_op(2, 8'hFE, 8'h09);
        #1 check("bp_ready1", 32'(req_ready), 32'b0100);
        tick();
        set_op(2, 8'h64, 8'h64);
        for (int c = 0; c < 3; c++) begin
            #1 check($sformatf("bp_stall%0d_ready", c), 32'(req_ready), 32'h0);
            check_rsp($sformatf("bp_hold%0d", c), 2'd2, 16'h000F);
            tick();
        end
        rsp_ready = 1'b1;
        #1 check("bp_resume_ready", 32'(req_ready), 32'b0100);
        check_rsp("bp_out0", 2'd2, 16'h000F);
        tick();
        req_valid = 4'b0000;
        #1 check_rsp("bp_out1", 2'd2, 16'hFFEE);
        tick();
        check_rsp("bp_out2", 2'd2, 16'h2710);
        tick();
        check("bp_drained", 32'(rsp_valid), 32'h0);

        // Wrap/skip with ptr=3
        set_op(1, 8'hFF, 8'hFF);
        set_op(2, 8'h05, 8'hFB);
        set_op(3, 8'h02, 8'h02);
        req_valid = 4'b0110;
        #1 check("wrap_ready0", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b0100;
        #1 check("wrap_ready1", 32'(req_ready), 32'b0100);
        tick();
        req_valid = 4'b1111;
        #1 check("wrap_ptr3_ready", 32'(req_ready), 32'b1000);
        check_rsp("wrap_out0", 2'd1, 16'h0001);
        tick();
        req_valid = 4'b0000;
        #1 check_rsp("wrap_out1", 2'd2, 16'hFFE7);
        tick();
        check_rsp("wrap_out2", 2'd3, 16'h0004);
        tick();
        check("wrap_drained", 32'(rsp_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_checks, num_fail);
        $finish;
    end

endmodule
